// File: rtl/error_report_parser_pkg.sv
// Shared constants, parser state encoding and field-size helper for the error-report parser.
package error_report_pkg;

    localparam logic [7:0] CHAR_E  = 8'h45;
    localparam logic [7:0] CHAR_L  = 8'h4C;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L_CR,
        ST_L_LF,
        ST_E_SP,
        ST_FIELD,
        ST_E_CR,
        ST_E_LF,
        ST_HOLD
    } parser_state_e;

    // Number of hex digits needed to carry a field of the given bit width.
    function automatic int unsigned hex_digits(input int unsigned width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/error_report_parser_hex_char_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f map to a nibble with is_hex_o set.
module hex_char_decode (
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            nibble_o = char_i[3:0];
            is_hex_o = 1'b1;
        end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                     (char_i >= 8'h61 && char_i <= 8'h66)) begin
            nibble_o = char_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/error_report_parser.sv
// Decodes ASCII "L" and "E" report frames from a byte stream into loop pulses and error records.
// Defining ERROR_REPORT_PARSER_COUNTERS_EN adds saturating error_count/loop_count outputs.
module error_report_parser
    import error_report_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 1,
    parameter int STATE_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_data_valid,
    output logic                   rx_data_ready,
    output logic                   report_valid,
    input  logic                   report_ready,
    output logic [STATE_WIDTH-1:0] error_state,
    output logic [ADDR_WIDTH-1:0]  error_address,
    output logic [DATA_WIDTH-1:0]  expected_data,
    output logic [DATA_WIDTH-1:0]  actual_data,
`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
    output logic [15:0]            error_count,
    output logic [15:0]            loop_count,
`endif
    output logic                   loop_complete,
    output logic                   framing_error
);

    localparam logic [3:0] STATE_LAST = 4'(hex_digits(STATE_WIDTH) - 1);
    localparam logic [3:0] ADDR_LAST  = 4'(hex_digits(ADDR_WIDTH) - 1);
    localparam logic [3:0] DATA_LAST  = 4'(hex_digits(DATA_WIDTH) - 1);

    parser_state_e          state_q, state_d;
    logic [1:0]             field_idx_q, field_idx_d;
    logic [3:0]             digit_cnt_q, digit_cnt_d;
    logic [STATE_WIDTH-1:0] st_sh_q, st_sh_d, st_out_q;
    logic [ADDR_WIDTH-1:0]  ad_sh_q, ad_sh_d, ad_out_q;
    logic [DATA_WIDTH-1:0]  ex_sh_q, ex_sh_d, ex_out_q;
    logic [DATA_WIDTH-1:0]  ac_sh_q, ac_sh_d, ac_out_q;
    logic                   loop_q, loop_d, ferr_q, ferr_d;
    logic                   commit, bad_byte, rx_fire, is_hex;
    logic [3:0]             nibble, field_last;

    // Shifting a whole digit in and keeping only the low bits truncates oversize values.
    logic [STATE_WIDTH+3:0] st_wide;
    logic [ADDR_WIDTH+3:0]  ad_wide;
    logic [DATA_WIDTH+3:0]  ex_wide, ac_wide;
    logic                   unused_wide;

    hex_char_decode u_hex (
        .char_i   (rx_data),
        .nibble_o (nibble),
        .is_hex_o (is_hex)
    );

    assign st_wide     = {st_sh_q, nibble};
    assign ad_wide     = {ad_sh_q, nibble};
    assign ex_wide     = {ex_sh_q, nibble};
    assign ac_wide     = {ac_sh_q, nibble};
    assign unused_wide = ^{st_wide[STATE_WIDTH+3:STATE_WIDTH], ad_wide[ADDR_WIDTH+3:ADDR_WIDTH],
                           ex_wide[DATA_WIDTH+3:DATA_WIDTH], ac_wide[DATA_WIDTH+3:DATA_WIDTH]};

    assign rx_data_ready = (state_q != ST_HOLD);
    assign rx_fire       = rx_data_valid && rx_data_ready;

    always_comb begin
        case (field_idx_q)
            2'd0:    field_last = STATE_LAST;
            2'd1:    field_last = ADDR_LAST;
            default: field_last = DATA_LAST;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        field_idx_d = field_idx_q;
        digit_cnt_d = digit_cnt_q;
        st_sh_d     = st_sh_q;
        ad_sh_d     = ad_sh_q;
        ex_sh_d     = ex_sh_q;
        ac_sh_d     = ac_sh_q;
        loop_d      = 1'b0;
        ferr_d      = 1'b0;
        commit      = 1'b0;
        bad_byte    = 1'b0;

        if (rx_fire) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == CHAR_E) begin
                        state_d     = ST_E_SP;
                        field_idx_d = 2'd0;
                        digit_cnt_d = 4'd0;
                    end else if (rx_data == CHAR_L) begin
                        state_d = ST_L_CR;
                    end
                end
                ST_L_CR: if (rx_data == CHAR_CR) state_d = ST_L_LF; else bad_byte = 1'b1;
                ST_L_LF: begin
                    if (rx_data == CHAR_LF) begin
                        loop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_E_SP: if (rx_data == CHAR_SP) state_d = ST_FIELD; else bad_byte = 1'b1;
                ST_FIELD: begin
                    if (is_hex) begin
                        case (field_idx_q)
                            2'd0:    st_sh_d = st_wide[STATE_WIDTH-1:0];
                            2'd1:    ad_sh_d = ad_wide[ADDR_WIDTH-1:0];
                            2'd2:    ex_sh_d = ex_wide[DATA_WIDTH-1:0];
                            default: ac_sh_d = ac_wide[DATA_WIDTH-1:0];
                        endcase
                        if (digit_cnt_q == field_last) begin
                            digit_cnt_d = 4'd0;
                            if (field_idx_q == 2'd3) begin
                                state_d = ST_E_CR;
                            end else begin
                                field_idx_d = field_idx_q + 2'd1;
                                state_d     = ST_E_SP;
                            end
                        end else begin
                            digit_cnt_d = digit_cnt_q + 4'd1;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_E_CR: if (rx_data == CHAR_CR) state_d = ST_E_LF; else bad_byte = 1'b1;
                ST_E_LF: begin
                    if (rx_data == CHAR_LF) begin
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                default: ;
            endcase

            // The offending byte is consumed; a frame-start character opens a new frame at once.
            if (bad_byte) begin
                ferr_d      = 1'b1;
                state_d     = ST_IDLE;
                field_idx_d = 2'd0;
                digit_cnt_d = 4'd0;
                if (rx_data == CHAR_E)      state_d = ST_E_SP;
                else if (rx_data == CHAR_L) state_d = ST_L_CR;
            end
        end

        if (state_q == ST_HOLD && report_ready) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            field_idx_q <= 2'd0;
            digit_cnt_q <= 4'd0;
            st_sh_q     <= '0;
            ad_sh_q     <= '0;
            ex_sh_q     <= '0;
            ac_sh_q     <= '0;
            st_out_q    <= '0;
            ad_out_q    <= '0;
            ex_out_q    <= '0;
            ac_out_q    <= '0;
            loop_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_idx_q <= field_idx_d;
            digit_cnt_q <= digit_cnt_d;
            st_sh_q     <= st_sh_d;
            ad_sh_q     <= ad_sh_d;
            ex_sh_q     <= ex_sh_d;
            ac_sh_q     <= ac_sh_d;
            loop_q      <= loop_d;
            ferr_q      <= ferr_d;
            if (commit) begin
                st_out_q <= st_sh_d;
                ad_out_q <= ad_sh_d;
                ex_out_q <= ex_sh_d;
                ac_out_q <= ac_sh_d;
            end
        end
    end

`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
    logic [15:0] err_cnt_q, loop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= 16'd0;
            loop_cnt_q <= 16'd0;
        end else begin
            if (commit && err_cnt_q != 16'hFFFF)  err_cnt_q  <= err_cnt_q + 16'd1;
            if (loop_d && loop_cnt_q != 16'hFFFF) loop_cnt_q <= loop_cnt_q + 16'd1;
        end
    end

    assign error_count = err_cnt_q;
    assign loop_count  = loop_cnt_q;
`endif

    assign report_valid  = (state_q == ST_HOLD);
    assign error_state   = st_out_q;
    assign error_address = ad_out_q;
    assign expected_data = ex_out_q;
    assign actual_data   = ac_out_q;
    assign loop_complete = loop_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_error_report_parser.sv
// Directed self-checking bench for error_report_parser (default widths: state 1, address 3, data 1 digit).
module tb_error_report_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic       rx_data_ready;
    logic       report_valid;
    logic       report_ready = 1'b0;
    logic [1:0] error_state;
    logic [9:0] error_address;
    logic [0:0] expected_data;
    logic [0:0] actual_data;
    logic       loop_complete;
    logic       framing_error;
`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
    logic [15:0] error_count;
    logic [15:0] loop_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int fe_seen = 0;
    int lc_seen = 0;

    error_report_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .error_state   (error_state),
        .error_address (error_address),
        .expected_data (expected_data),
        .actual_data   (actual_data),
`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
        .error_count   (error_count),
        .loop_count    (loop_count),
`endif
        .loop_complete (loop_complete),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_seen++;
        if (loop_complete === 1'b1) lc_seen++;
    end

    // Presents one byte at the falling edge; it transfers at the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        waited        = 0;
        while (rx_data_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: rx_data_ready got %b want 1", rx_data_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_crlf();
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    // Falls to the next falling edge and stops driving bytes.
    task automatic settle();
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        report_ready = 1'b1;
        @(negedge clk);
        report_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (rx_data_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", rx_data_ready); end
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", report_valid); end
        vectors++; if ({error_state, error_address, expected_data, actual_data} !== 14'd0) begin
            miscompares++; $display("FAIL rst_fields: got %h/%h/%h/%h want 0", error_state, error_address, expected_data, actual_data); end
        vectors++; if ({loop_complete, framing_error} !== 2'b00) begin
            miscompares++; $display("FAIL rst_pulses: got %b%b want 00", loop_complete, framing_error); end
        rst_n = 1'b1;
    endtask

    task automatic test_error_frame();
        int fe0;
        fe0 = fe_seen;
        send_str("E 2 3FF 1 0");
        send_crlf();
        settle();
        for (int c = 0; c < 5; c++) begin
            vectors++; if (report_valid !== 1'b1) begin miscompares++; $display("FAIL ef_valid c%0d: got %b want 1", c, report_valid); end
            vectors++; if (rx_data_ready !== 1'b0) begin miscompares++; $display("FAIL ef_ready c%0d: got %b want 0", c, rx_data_ready); end
            vectors++; if ({error_state, error_address, expected_data, actual_data} !== {2'd2, 10'h3FF, 1'b1, 1'b0}) begin
                miscompares++; $display("FAIL ef_fields c%0d: got %h/%h/%h/%h want 2/3ff/1/0", c, error_state, error_address, expected_data, actual_data); end
            if (c < 4) @(negedge clk);
        end
        report_ready = 1'b1;
        @(negedge clk);
        report_ready = 1'b0;
        vectors++; if (rx_data_ready !== 1'b1) begin miscompares++; $display("FAIL ef_ack_ready: got %b want 1", rx_data_ready); end
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL ef_ack_valid: got %b want 0", report_valid); end
        vectors++; if (fe_seen !== fe0) begin miscompares++; $display("FAIL ef_no_ferr: got %0d want %0d", fe_seen, fe0); end
    endtask

    task automatic test_truncation();
        int fe0;
        fe0 = fe_seen;
        send_str("E 3 7a5 0 1");
        send_crlf();
        settle();
        vectors++; if (report_valid !== 1'b1) begin miscompares++; $display("FAIL tr_valid: got %b want 1", report_valid); end
        vectors++; if (error_address !== 10'h3A5) begin miscompares++; $display("FAIL tr_addr: got %h want 3a5", error_address); end
        vectors++; if ({error_state, expected_data, actual_data} !== {2'd3, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL tr_fields: got %h/%h/%h want 3/0/1", error_state, expected_data, actual_data); end
        ack();
        vectors++; if (fe_seen !== fe0) begin miscompares++; $display("FAIL tr_no_ferr: got %0d want %0d", fe_seen, fe0); end
    endtask

    task automatic test_loop();
        int fe0, lc0;
        fe0 = fe_seen; lc0 = lc_seen;
        send_byte(8'h0D);
        send_byte("x");
        send_byte("L");
        send_crlf();
        settle();
        vectors++; if (loop_complete !== 1'b1) begin miscompares++; $display("FAIL lp_pulse: got %b want 1", loop_complete); end
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL lp_valid: got %b want 0", report_valid); end
        @(negedge clk);
        vectors++; if (loop_complete !== 1'b0) begin miscompares++; $display("FAIL lp_pulse_end: got %b want 0", loop_complete); end
        @(negedge clk);
        vectors++; if (lc_seen - lc0 !== 1) begin miscompares++; $display("FAIL lp_count: got %0d want 1", lc_seen - lc0); end
        vectors++; if (fe_seen !== fe0) begin miscompares++; $display("FAIL lp_noise_ferr: got %0d want %0d", fe_seen, fe0); end
    endtask

    task automatic test_malformed();
        send_str("E 2 3G");
        settle();
        vectors++; if (framing_error !== 1'b1) begin miscompares++; $display("FAIL mf_pulse: got %b want 1", framing_error); end
        vectors++; if (error_address !== 10'h3A5) begin miscompares++; $display("FAIL mf_hold_addr: got %h want 3a5", error_address); end
        @(negedge clk);
        vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL mf_pulse_end: got %b want 0", framing_error); end
        send_str("E 1 001 1 1");
        send_crlf();
        settle();
        vectors++; if ({report_valid, error_state, error_address, expected_data, actual_data} !== {1'b1, 2'd1, 10'h001, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL mf_recover: got v%b %h/%h/%h/%h want v1 1/001/1/1", report_valid, error_state, error_address, expected_data, actual_data); end
        ack();
    endtask

    task automatic test_restart();
        int fe0, lc0;
        fe0 = fe_seen; lc0 = lc_seen;
        send_str("E 2 L");
        settle();
        vectors++; if (framing_error !== 1'b1) begin miscompares++; $display("FAIL rs_ferr: got %b want 1", framing_error); end
        send_crlf();
        settle();
        vectors++; if (loop_complete !== 1'b1) begin miscompares++; $display("FAIL rs_loop: got %b want 1", loop_complete); end
        @(negedge clk);
        vectors++; if ((fe_seen - fe0) !== 1 || (lc_seen - lc0) !== 1) begin
            miscompares++; $display("FAIL rs_counts: got fe%0d lc%0d want fe1 lc1", fe_seen - fe0, lc_seen - lc0); end
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid: got %b want 0", report_valid); end
    endtask

    task automatic test_back_to_back();
        int lc0;
        lc0 = lc_seen;
        send_str("L");
        send_crlf();
        send_str("L");
        send_crlf();
        settle();
        @(negedge clk);
        vectors++; if (lc_seen - lc0 !== 2) begin miscompares++; $display("FAIL bb_loops: got %0d want 2", lc_seen - lc0); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        send_str("E 1 0");
        settle();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if ({rx_data_ready, report_valid, loop_complete, framing_error} !== 4'b1000) begin
            miscompares++; $display("FAIL rm_ctrl: got %b want 1000", {rx_data_ready, report_valid, loop_complete, framing_error}); end
        vectors++; if ({error_state, error_address, expected_data, actual_data} !== 14'd0) begin
            miscompares++; $display("FAIL rm_fields: got %h/%h/%h/%h want 0", error_state, error_address, expected_data, actual_data); end
        rst_n = 1'b1;
        fe0 = fe_seen;
        send_str(" 1 1");
        send_crlf();
        settle();
        @(negedge clk);
        vectors++; if (report_valid !== 1'b0 || fe_seen !== fe0) begin
            miscompares++; $display("FAIL rm_discard: got valid%b fe%0d want valid0 fe%0d", report_valid, fe_seen, fe0); end
        send_str("E 1 2AB 1 0");
        send_crlf();
        settle();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if ({report_valid, rx_data_ready, error_address} !== {1'b0, 1'b1, 10'h000}) begin
            miscompares++; $display("FAIL rh_drop: got v%b r%b a%h want v0 r1 a000", report_valid, rx_data_ready, error_address); end
        rst_n = 1'b1;
    endtask

`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
    task automatic test_counters();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if ({error_count, loop_count} !== 32'd0) begin
            miscompares++; $display("FAIL cnt_rst: got %0d/%0d want 0/0", error_count, loop_count); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_str("E 1 123 0 1");
            send_crlf();
            settle();
            ack();
        end
        send_str("L");
        send_crlf();
        settle();
        vectors++; if (error_count !== 16'd3) begin miscompares++; $display("FAIL cnt_err: got %0d want 3", error_count); end
        vectors++; if (loop_count !== 16'd1) begin miscompares++; $display("FAIL cnt_loop: got %0d want 1", loop_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_error_frame();
        test_truncation();
        test_loop();
        test_malformed();
        test_restart();
        test_back_to_back();
        test_reset_midframe();
`ifdef ERROR_REPORT_PARSER_COUNTERS_EN
        test_counters();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
